// File: rtl/fetch_pkg.sv
// Shared types and default widths for the program-fetch sequencer.
package fetch_pkg;

   localparam int PC_W  = 12;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Host/decoder-facing bundle of the fetch sequencer.
interface fetch_ctrl_if
   import fetch_pkg::*;
#(
   parameter int D  = PC_W,
   parameter int CW = CNT_W
) ();

   logic          start;
   logic [D-1:0]  start_addr;
   logic          stall;
   logic          halt;
   logic          br_taken;
   logic          br_abs;
   logic [D-1:0]  br_target;
   logic [D-1:0]  prog_ctr;
   logic          fetch_valid;
   logic          busy;
   logic          done;
   logic [CW-1:0] instr_cnt;

   modport master (
      output start, start_addr, stall, halt,
      output br_taken, br_abs, br_target,
      input  prog_ctr, fetch_valid, busy, done,
      input  instr_cnt
   );

   modport slave (
      input  start, start_addr, stall, halt,
      input  br_taken, br_abs, br_target,
      output prog_ctr, fetch_valid, busy, done,
      output instr_cnt
   );

endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Next-PC adder: sequential step or branch target, wrapping at 2**D.
module pc_next
   import fetch_pkg::*;
#(
   parameter int D = PC_W
) (
   input  logic [D-1:0] pc,
   input  logic         br_taken,
   input  logic         br_abs,
   input  logic [D-1:0] br_target,
   output logic [D-1:0] nxt
);

   localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

   // D-bit adds truncate, so relative offsets act as two's complement
   always_comb begin
      nxt = pc + ONE;
      if (br_taken) begin
         nxt = br_abs ? br_target : pc + br_target;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, launch/halt FSM and retired-instruction count.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int D  = PC_W,
   parameter int CW = CNT_W
) (
   input logic         clk,
   input logic         reset,
   fetch_ctrl_if.slave bus
);

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   fetch_state_t  state, state_nxt;
   logic [D-1:0]  pc_q, pc_d, pc_adv;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

   pc_next #(.D(D)) u_pc_next (
      .pc        (pc_q),
      .br_taken  (bus.br_taken),
      .br_abs    (bus.br_abs),
      .br_target (bus.br_target),
      .nxt       (pc_adv)
   );

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

   always_comb begin
      state_nxt = state;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      unique case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_nxt = RUN;
               pc_d      = bus.start_addr;
               cnt_d     = '0;
            end
         end
         RUN: begin
            // halt outranks a simultaneous branch
            if (!bus.stall) begin
               cnt_d = cnt_inc;
               if (bus.halt) begin
                  state_nxt = DONE;
               end else begin
                  pc_d = pc_adv;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc_q  <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.prog_ctr    = pc_q;
   assign bus.instr_cnt   = cnt_q;
   assign bus.fetch_valid = (state == RUN);
   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed plan steps plus random traffic vs a model.
module tb_fetch_ctrl;

   logic clk;
   logic reset;

   fetch_ctrl_if #(.D(12), .CW(16)) b16 ();
   fetch_ctrl_if #(.D(12), .CW(4))  b4 ();

   assign b4.start      = b16.start;
   assign b4.start_addr = b16.start_addr;
   assign b4.stall      = b16.stall;
   assign b4.halt       = b16.halt;
   assign b4.br_taken   = b16.br_taken;
   assign b4.br_abs     = b16.br_abs;
   assign b4.br_target  = b16.br_target;

   fetch_ctrl #(.D(12), .CW(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b16)
   );

   fetch_ctrl #(.D(12), .CW(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: running/finished flags, PC as an integer, unbounded count
   bit m_run;
   bit m_done;
   int m_pc;
   int m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int e16;
      int e4;
      e16 = (m_cnt > 65535) ? 65535 : m_cnt;
      e4  = (m_cnt > 15) ? 15 : m_cnt;
      chk({tag, ".pc"}, 32'(b16.prog_ctr), 32'(m_pc));
      chk({tag, ".valid"}, 32'(b16.fetch_valid), 32'(m_run));
      chk({tag, ".busy"}, 32'(b16.busy), 32'(m_run));
      chk({tag, ".done"}, 32'(b16.done), 32'(m_done));
      chk({tag, ".cnt"}, 32'(b16.instr_cnt), 32'(e16));
      chk({tag, ".pc4"}, 32'(b4.prog_ctr), 32'(m_pc));
      chk({tag, ".cnt4"}, 32'(b4.instr_cnt), 32'(e4));
   endtask

   task automatic model_reset();
      m_run  = 0;
      m_done = 0;
      m_pc   = 0;
      m_cnt  = 0;
   endtask

   task automatic model_edge();
      int off;
      if (!m_run) begin
         if (b16.start) begin
            m_run  = 1;
            m_done = 0;
            m_pc   = int'(b16.start_addr);
            m_cnt  = 0;
         end
      end else if (b16.stall) begin
         m_run = 1;
      end else if (b16.halt) begin
         m_run  = 0;
         m_done = 1;
         m_cnt++;
      end else begin
         m_cnt++;
         if (b16.br_taken && b16.br_abs) begin
            m_pc = int'(b16.br_target);
         end else if (b16.br_taken) begin
            off  = int'($signed(b16.br_target));
            m_pc = ((m_pc + off) % 4096 + 4096) % 4096;
         end else begin
            m_pc = (m_pc + 1) % 4096;
         end
      end
   endtask

   task automatic drive(input bit st, input logic [11:0] sa, input bit sl,
                        input bit h, input bit bt, input bit ba,
                        input logic [11:0] tg);
      b16.start      = st;
      b16.start_addr = sa;
      b16.stall      = sl;
      b16.halt       = h;
      b16.br_taken   = bt;
      b16.br_abs     = ba;
      b16.br_target  = tg;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 12'h000, 0, 0, 0, 0, 12'h000);
      model_reset();
      #3;
      check_all("reset");
      #9;
      reset = 1'b0;

      // launch at 0, five fetches
      drive(1, 12'h000, 0, 0, 0, 0, 12'h000);
      tick("launch0");
      drive(0, 12'h000, 0, 0, 0, 0, 12'h000);
      repeat (4) tick("seq");
      chk("seq.cnt4", 32'(b16.instr_cnt), 32'd4);
      drive(0, 12'h000, 0, 1, 0, 0, 12'h000);
      tick("halt1");
      drive(0, 12'h000, 0, 0, 0, 0, 12'h000);
      tick("done_hold");

      // absolute then backward relative branch
      drive(1, 12'h010, 0, 0, 0, 0, 12'h000);
      tick("launch10");
      drive(0, 12'h000, 0, 0, 1, 1, 12'h3A0);
      tick("jabs");
      chk("jabs.lit", 32'(b16.prog_ctr), 32'h3A0);
      drive(0, 12'h000, 0, 0, 1, 0, 12'hFFE);
      tick("jrel_back");
      chk("jrel.lit", 32'(b16.prog_ctr), 32'h39E);
      drive(1, 12'h555, 0, 0, 0, 0, 12'h000);
      tick("start_in_run");
      drive(0, 12'h000, 0, 1, 0, 0, 12'h000);
      tick("halt2");

      // wraps
      drive(1, 12'hFFF, 0, 0, 0, 0, 12'h000);
      tick("launchFFF");
      drive(0, 12'h000, 0, 0, 0, 0, 12'h000);
      tick("wrap_seq");
      chk("wrap.lit", 32'(b16.prog_ctr), 32'h000);
      drive(0, 12'h000, 0, 0, 1, 1, 12'hFFE);
      tick("toFFE");
      drive(0, 12'h000, 0, 0, 1, 0, 12'h004);
      tick("wrap_rel");
      chk("wraprel.lit", 32'(b16.prog_ctr), 32'h002);

      // stall with halt pending
      drive(0, 12'h000, 0, 0, 1, 1, 12'h005);
      tick("to005");
      drive(0, 12'h000, 1, 1, 1, 1, 12'h300);
      repeat (3) tick("stall");
      drive(0, 12'h000, 0, 1, 0, 0, 12'h000);
      tick("unstall_halt");
      chk("unstall.done", 32'(b16.done), 32'd1);

      // relaunch from DONE, then halt beats branch
      drive(1, 12'h100, 0, 0, 0, 0, 12'h000);
      tick("relaunch100");
      chk("relaunch.cnt", 32'(b16.instr_cnt), 32'd0);
      drive(0, 12'h000, 0, 1, 1, 1, 12'h200);
      tick("halt_vs_br");
      chk("halt_vs_br.lit", 32'(b16.prog_ctr), 32'h100);

      // start held high across a whole program and into the next launch
      drive(1, 12'h020, 0, 0, 0, 0, 12'h000);
      repeat (3) tick("start_held");
      drive(1, 12'h020, 0, 1, 0, 0, 12'h000);
      tick("halt_held");
      drive(1, 12'h040, 0, 0, 0, 0, 12'h000);
      tick("relaunch_held");

      // long run to saturate the 4-bit counter
      drive(0, 12'h000, 0, 0, 0, 0, 12'h000);
      repeat (20) tick("sat");
      chk("sat.cnt4", 32'(b4.instr_cnt), 32'd15);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) == 0, 12'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 3) == 0, 1'($urandom),
               12'($urandom));
         tick("rand");
      end

      // asynchronous abort mid-RUN
      drive(1, 12'h0AB, 0, 0, 0, 0, 12'h000);
      tick("launchAB");
      drive(0, 12'h000, 0, 0, 0, 0, 12'h000);
      tick("runAB");
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #2;
      reset = 1'b0;
      tick("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-fetch sequencer for the 9-bit core: owns the program counter that addresses the instruction ROM, starts and stops program execution with a start/done handshake, and applies branch, jump, halt and stall requests from the decoder. The instruction ROM is combinational, so the word at `prog_ctr` is available in the same cycle. This block sits between the top-level testbench/host handshake and the ROM address port, with the decoder feeding control back to it.

## Interface
- `D`, 12: PC / ROM address width; ROM depth is 2**D.
- `CW`, 16: width of the retired-instruction counter.
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: level; sampled in IDLE or DONE to launch a program.
- `start_addr`  in  D: PC loaded on launch.
- `stall`  in  1: hold the PC and ignore decoder requests this cycle.
- `halt`  in  1: decoder reports that the current word is a halt instruction.
- `br_taken`  in  1: decoder reports a taken branch/jump on the current word.
- `br_abs`  in  1: 1 = absolute target; 0 = PC-relative offset.
- `br_target`  in  D: absolute target, or two's-complement offset when `br_abs`=0.
- `prog_ctr`  out  D: ROM address.
- `fetch_valid`  out  1: `prog_ctr` points at a live instruction (RUN state).
- `busy`  out  1: high in RUN.
- `done`  out  1: high in DONE.
- `instr_cnt`  out  CW: instructions retired since the last launch; saturates.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE:
  - `start`=1 → RUN, `prog_ctr`←`start_addr`, `instr_cnt`←0.
  - Otherwise hold.
- RUN, each edge, in priority order:
  1. `stall`=1: hold everything. `halt` and `br_*` are ignored that cycle.
  2. `halt`=1: → DONE. `prog_ctr` holds at the halt word's address. `instr_cnt`+1 (the halt counts as retired).
  3. `br_taken`=1:
     - `br_abs`=1: `prog_ctr`←`br_target`.
     - `br_abs`=0: `prog_ctr`←`prog_ctr`+`br_target`, modulo 2**D.
     - `instr_cnt`+1.
  4. Else: `prog_ctr`←`prog_ctr`+1, modulo 2**D (2**D−1 wraps to 0). `instr_cnt`+1.
- `start` is ignored in RUN.
- DONE:
  - Outputs hold.
  - `start`=1 → RUN with a fresh launch, identical to launching from IDLE.
  - No need to drop `start` between programs.
- `instr_cnt` saturates at 2**CW−1 and never wraps.
- Relative offset arithmetic:
  - `br_target` is sign-extended conceptually.
  - The D-bit sum is truncated, so backward branches wrap below 0 to high addresses.
- `halt` and `br_taken` both asserted: `halt` wins and the branch is discarded.

## Timing
- Reset values: `prog_ctr`=0, `instr_cnt`=0, `fetch_valid`=0, `busy`=0, `done`=0, state IDLE.
- Reset mid-RUN aborts at once and returns to IDLE. No completion is reported.
- Launch latency:
  - `start` sampled at edge N.
  - `prog_ctr`=`start_addr` and `fetch_valid`=1 from edge N+1.
  - First instruction word is valid combinationally in cycle N+1.
- One instruction per cycle when not stalled. Decoder inputs are sampled at the edge that closes the cycle in which `prog_ctr` presented the word.
- Branch penalty is zero: the target address appears on the edge after the branch word.
- Halt:
  - `done`=1 and `busy`=`fetch_valid`=0 from the edge after the halt word.
  - `done` stays high until the next launch edge, after which it is 0.
- Outputs are registered. `fetch_valid`, `busy` and `done` decode from state flops only. No combinational path from any input to any output.

## Structure
- Shared package `fetch_pkg`:
  - State enum `fetch_state_t` {IDLE, RUN, DONE}.
  - Default widths `PC_W`=12 and `CNT_W`=16, used for `D` and `CW`.
- Sub-module `pc_next` (combinational): takes PC, `br_taken`, `br_abs`, `br_target` and returns the next sequential or branch PC with D-bit wrap. It keeps the adder logic separable for unit test.
- Top `fetch_ctrl` holds the FSM, PC register, counter and priority logic, and instantiates `pc_next`.

## Test plan
- Reset then launch: `reset` pulse, `start`=1 with `start_addr`=0 for one cycle, 5 unstalled cycles → `prog_ctr` 0,1,2,3,4; `instr_cnt`=4 after the 5th fetch edge; `busy`=1.
- Branches: `start_addr`=0x010 with an absolute jump at PC 0x010 to 0x3A0 → next PC 0x3A0. A relative jump at 0x3A0 with `br_target`=0xFFE (−2) → next PC 0x39E.
- Wraps: start at 0xFFF with no branch → next PC 0x000. A relative +4 branch from 0xFFE → 0x002.
- Stall plus simultaneous events: `stall`=1 for 3 cycles at PC 0x005 with `halt`=1 → PC holds at 0x005, no DONE, `instr_cnt` unchanged. Release stall → DONE next edge, `done`=1. `halt` and `br_taken` asserted together → DONE, no jump.
- Relaunch and reset abort: in DONE, `start`=1 with `start_addr`=0x100 → RUN, `prog_ctr`=0x100, `instr_cnt`=0, `done`=0. `reset` asserted mid-cycle in RUN → outputs go to 0 immediately, without waiting for a clock edge.
- Saturation: instantiate with `CW`=4 and run 20 instructions → `instr_cnt` sticks at 15.
